// File: rtl/regfile_wb_arbiter.sv
// Write-port master for the 32x32 register file: merges main-pipe writebacks with
// buffered multi-cycle results and flags read-after-write hazards to decode.
module regfile_wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pipe_we,
  input  logic [4:0]    pipe_no,
  input  logic [31:0]   pipe_data,
  input  logic          mc_valid,
  output logic          mc_ready,
  input  logic [4:0]    mc_no,
  input  logic [31:0]   mc_data,
  output logic          reg_write,
  output logic [4:0]    reg_no_in,
  output logic [31:0]   reg_data_in,
  input  logic [4:0]    chk1_no,
  input  logic [4:0]    chk2_no,
  output logic          chk_pending,
  output logic [AW:0]   fifo_count
);

  logic [4:0]       entry_no   [DEPTH];
  logic [31:0]      entry_data [DEPTH];
  logic [DEPTH-1:0] entry_valid;
  logic [DEPTH-1:0] valid_next;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             pipe_issue;
  logic             transfer;
  logic             push;
  logic             pop;
  logic [DEPTH-1:0] hit1;
  logic [DEPTH-1:0] hit2;

  assign fifo_count = count;
  assign mc_ready   = !rst && (count < (AW+1)'(DEPTH));
  assign pipe_issue = pipe_we && (pipe_no != '0);
  assign transfer   = mc_valid && mc_ready;
  // r0 results and results overtaken by a same-cycle pipe write to the same register are dropped
  assign push       = transfer && (mc_no != '0) && !(pipe_we && (pipe_no == mc_no));
  assign pop        = !pipe_issue && (count != '0);

  always_comb begin
    valid_next = entry_valid;
    for (int i = 0; i < DEPTH; i++) begin
      if (pipe_issue && (entry_no[i] == pipe_no)) begin
        valid_next[i] = 1'b0;
      end
    end
    if (pop) begin
      valid_next[rd_ptr] = 1'b0;
    end
    if (push) begin
      valid_next[wr_ptr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      entry_valid <= '0;
      reg_write   <= 1'b0;
      reg_no_in   <= '0;
      reg_data_in <= '0;
    end else begin
      entry_valid <= valid_next;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + (AW+1)'(1);
      end else if (pop && !push) begin
        count <= count - (AW+1)'(1);
      end
      if (pipe_issue) begin
        reg_write   <= 1'b1;
        reg_no_in   <= pipe_no;
        reg_data_in <= pipe_data;
      end else if (pop) begin
        // a killed head still pops, but as a bubble
        reg_write   <= entry_valid[rd_ptr];
        reg_no_in   <= entry_no[rd_ptr];
        reg_data_in <= entry_data[rd_ptr];
      end else begin
        reg_write <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      entry_no[wr_ptr]   <= mc_no;
      entry_data[wr_ptr] <= mc_data;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
    assign hit1[gi] = entry_valid[gi] && (entry_no[gi] == chk1_no);
    assign hit2[gi] = entry_valid[gi] && (entry_no[gi] == chk2_no);
  end

  assign chk_pending = ((chk1_no != '0) && ((reg_write && (reg_no_in == chk1_no)) || (|hit1))) ||
                       ((chk2_no != '0) && ((reg_write && (reg_no_in == chk2_no)) || (|hit2)));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-based reference model.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_no;
  logic [31:0] pipe_data;
  logic        mc_valid;
  logic        mc_ready;
  logic [4:0]  mc_no;
  logic [31:0] mc_data;
  logic        reg_write;
  logic [4:0]  reg_no_in;
  logic [31:0] reg_data_in;
  logic [4:0]  chk1_no;
  logic [4:0]  chk2_no;
  logic        chk_pending;
  logic [2:0]  fifo_count;

  regfile_wb_arbiter #(.DEPTH(4), .AW(2)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_no(pipe_no), .pipe_data(pipe_data),
    .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_no(mc_no), .mc_data(mc_data),
    .reg_write(reg_write), .reg_no_in(reg_no_in), .reg_data_in(reg_data_in),
    .chk1_no(chk1_no), .chk2_no(chk2_no), .chk_pending(chk_pending),
    .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  no;
    logic [31:0] data;
    bit          valid;
  } ent_t;

  ent_t        q[$];
  bit          exp_we;
  logic [4:0]  exp_no;
  logic [31:0] exp_data;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit pend(input logic [4:0] n);
    bit r = 1'b0;
    if (n != 5'd0) begin
      if (exp_we && exp_no == n) r = 1'b1;
      foreach (q[i]) if (q[i].valid && q[i].no == n) r = 1'b1;
    end
    return r;
  endfunction

  task automatic model_reset();
    q.delete();
    exp_we   = 1'b0;
    exp_no   = '0;
    exp_data = '0;
  endtask

  task automatic compare_all();
    bit exp_ready;
    exp_ready = !rst && (q.size() < 4);
    chk("reg_write", {31'd0, reg_write}, {31'd0, exp_we});
    if (exp_we) begin
      chk("reg_no_in", {27'd0, reg_no_in}, {27'd0, exp_no});
      chk("reg_data_in", reg_data_in, exp_data);
    end
    chk("fifo_count", {29'd0, fifo_count}, q.size());
    chk("mc_ready", {31'd0, mc_ready}, {31'd0, exp_ready});
    chk("chk_pending", {31'd0, chk_pending}, {31'd0, pend(chk1_no) || pend(chk2_no)});
  endtask

  // Next-cycle model state from the current inputs, straight from the write-port rules
  task automatic model_step();
    bit   xfer;
    bit   issue;
    ent_t e;
    xfer  = mc_valid && (q.size() < 4);
    issue = pipe_we && (pipe_no != 5'd0);
    if (issue) begin
      exp_we = 1'b1; exp_no = pipe_no; exp_data = pipe_data;
      foreach (q[i]) if (q[i].no == pipe_no) q[i].valid = 1'b0;
    end else if (q.size() > 0) begin
      e = q.pop_front();
      exp_we = e.valid;
      if (e.valid) begin
        exp_no = e.no; exp_data = e.data;
      end
    end else begin
      exp_we = 1'b0;
    end
    if (xfer && mc_no != 5'd0 && !(pipe_we && pipe_no == mc_no)) begin
      e.no = mc_no; e.data = mc_data; e.valid = 1'b1;
      q.push_back(e);
    end
    if (exp_we) $display("write r%0d <= %08h at %0t", exp_no, exp_data, $time);
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge
  task automatic step();
    if (rst) model_reset();
    #1;
    compare_all();
    if (!rst) model_step();
    @(negedge clk);
  endtask

  task automatic drive(input bit pw, input logic [4:0] pn, input logic [31:0] pd,
                       input bit mv, input logic [4:0] mn, input logic [31:0] md);
    pipe_we = pw; pipe_no = pn; pipe_data = pd;
    mc_valid = mv; mc_no = mn; mc_data = md;
  endtask

  initial begin
    rst = 1'b1;
    chk1_no = '0; chk2_no = '0;
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    #1;
    chk("rst_reg_write", {31'd0, reg_write}, 32'd0);
    chk("rst_reg_no_in", {27'd0, reg_no_in}, 32'd0);
    chk("rst_reg_data_in", reg_data_in, 32'd0);
    chk("rst_fifo_count", {29'd0, fifo_count}, 32'd0);
    chk("rst_mc_ready", {31'd0, mc_ready}, 32'd0);
    chk("rst_chk_pending", {31'd0, chk_pending}, 32'd0);
    step();
    rst = 1'b0;
    step();

    // single pipe writeback appears one cycle later, then drops
    drive(1, 5, 32'hA5A5A5A5, 0, 0, 0);
    step();
    chk("pipe_we", {31'd0, reg_write}, 32'd1);
    chk("pipe_no", {27'd0, reg_no_in}, 32'd5);
    chk("pipe_data", reg_data_in, 32'hA5A5A5A5);
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("pipe_idle", {31'd0, reg_write}, 32'd0);

    // fill FIFO behind continuous pipe writes, then drain in order
    for (int k = 0; k < 4; k++) begin
      drive(1, 5'(k + 1), 32'h100 + k, 1, 5'(10 + k), 32'h200 + k);
      step();
    end
    chk("full_count", {29'd0, fifo_count}, 32'd4);
    chk("full_ready", {31'd0, mc_ready}, 32'd0);
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("drain_we", {31'd0, reg_write}, 32'd1);
      chk("drain_no", {27'd0, reg_no_in}, 32'(10 + k));
      chk("drain_data", reg_data_in, 32'h200 + k);
    end
    step();

    // buffered r7 killed by a younger pipe write, then pops as a bubble
    drive(0, 0, 0, 1, 7, 32'h11);
    step();
    drive(1, 7, 32'h22, 0, 0, 0);
    step();
    chk("waw_no", {27'd0, reg_no_in}, 32'd7);
    chk("waw_data", reg_data_in, 32'h22);
    chk("waw_count", {29'd0, fifo_count}, 32'd1);
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("bubble_we", {31'd0, reg_write}, 32'd0);
    chk("bubble_count", {29'd0, fifo_count}, 32'd0);

    // same-cycle mc and pipe to r9: mc result dropped
    drive(1, 9, 32'h77, 1, 9, 32'h99);
    #1;
    chk("r9_ready", {31'd0, mc_ready}, 32'd1);
    step();
    chk("r9_data", reg_data_in, 32'h77);
    chk("r9_count", {29'd0, fifo_count}, 32'd0);
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("r9_nowrite", {31'd0, reg_write}, 32'd0);

    // hazard tracking on a queued r3 through its write
    drive(1, 20, 32'h20, 1, 3, 32'h33);
    step();
    chk1_no = 3;
    drive(1, 21, 32'h21, 0, 0, 0);
    step();
    chk("haz_queued", {31'd0, chk_pending}, 32'd1);
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("haz_issuing_no", {27'd0, reg_no_in}, 32'd3);
    chk("haz_issuing", {31'd0, chk_pending}, 32'd1);
    step();
    chk("haz_clear", {31'd0, chk_pending}, 32'd0);
    chk1_no = 0;
    drive(0, 0, 0, 1, 0, 32'h55);
    step();
    chk("r0_count", {29'd0, fifo_count}, 32'd0);
    chk("r0_pending", {31'd0, chk_pending}, 32'd0);
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("r0_nowrite", {31'd0, reg_write}, 32'd0);

    // reset with three queued entries
    for (int k = 0; k < 3; k++) begin
      drive(1, 5'(k + 1), 32'h300 + k, 1, 5'(4 + k), 32'h400 + k);
      step();
    end
    chk("pre_rst_count", {29'd0, fifo_count}, 32'd3);
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_count", {29'd0, fifo_count}, 32'd0);
    chk("mid_rst_we", {31'd0, reg_write}, 32'd0);
    step();
    rst = 1'b0;
    step();

    // randomized traffic on a narrow register range to force collisions
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom);
      chk1_no = 5'($urandom_range(0, 7));
      chk2_no = 5'($urandom_range(0, 7));
      step();
    end
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 6; n++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
